// File: rtl/mcu_debug_bridge_pkg.sv
// Shared types for the MCU debug bridge: FSM states, access sizes and command decode.
package debug_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED,
    ST_REG,
    ST_MEM,
    ST_RST
  } dbg_state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Exactly one field set means a well-formed command.
  typedef struct packed {
    logic pause;
    logic resume;
    logic dbg_reset;
    logic reg_rd;
    logic reg_wr;
    logic mem_rd;
    logic mem_wr;
  } dbg_cmd_t;

  function automatic logic [31:0] size_mask(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] r;
    case (size)
      SZ_BYTE: r = {24'b0, data[7:0]};
      SZ_HALF: r = {16'b0, data[15:0]};
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mcu_debug_bridge.sv
// Converts debug-controller command strobes into Otter MCU control, register-file and
// memory accesses; tracks run/halt state and reports read data, busy and errors.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   RUN    | MCU free-running; accepts pause/resume/dbg_reset
//   DRAIN  | stall asserted, waiting for mcu_idle (bounded by DRAIN_MAX)
//   HALTED | MCU frozen; accepts every command
//   REG    | one-cycle register-file read or write
//   MEM    | memory request held until dm_ack or MEM_TIMEOUT
//   RST    | mcu_rst held for RST_CYCLES, then back to prior idle state
module mcu_debug_bridge
  import debug_pkg::*;
#(
  parameter int RST_CYCLES  = 4,
  parameter int MEM_TIMEOUT = 255,
  parameter int DRAIN_MAX   = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pause,
  input  logic        resume,
  input  logic        dbg_reset,
  input  logic        reg_rd,
  input  logic        reg_wr,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [1:0]  mem_size,
  input  logic        valid,
  input  logic [31:0] addr,
  input  logic [31:0] d_in,
  output logic [31:0] d_rd,
  output logic        mcu_busy,
  output logic        error,
  output logic [31:0] pc,
  input  logic [31:0] mcu_pc,
  input  logic        mcu_idle,
  output logic        mcu_stall,
  output logic        mcu_rst,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_wd,
  output logic        rf_we,
  input  logic [31:0] rf_rd,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_din,
  output logic [1:0]  dm_size,
  output logic        dm_re,
  output logic        dm_we,
  input  logic        dm_ack,
  input  logic [31:0] dm_dout
);

  localparam int CNT_MAX = (RST_CYCLES > MEM_TIMEOUT)
                           ? ((RST_CYCLES > DRAIN_MAX) ? RST_CYCLES : DRAIN_MAX)
                           : ((MEM_TIMEOUT > DRAIN_MAX) ? MEM_TIMEOUT : DRAIN_MAX);
  localparam int CW = $clog2(CNT_MAX + 1);

  dbg_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d, din_q, din_d, d_rd_d;
  logic [1:0]    size_q, size_d;
  logic          op_wr_q, op_wr_d, ret_halted_q, ret_halted_d, err_d;

  dbg_cmd_t cmd;
  logic     is_reg, is_mem, bad_align, illegal;

  assign cmd       = dbg_cmd_t'({pause, resume, dbg_reset, reg_rd, reg_wr, mem_rd, mem_wr});
  assign is_reg    = cmd.reg_rd | cmd.reg_wr;
  assign is_mem    = cmd.mem_rd | cmd.mem_wr;
  assign bad_align = (mem_size == SZ_HALF && addr[0]) ||
                     (mem_size == SZ_WORD && addr[1:0] != 2'b00);
  assign illegal   = ($countones(cmd) != 1) ||
                     ((is_reg || is_mem) && state_q == ST_RUN) ||
                     (is_reg && addr[31:5] != '0) ||
                     (is_mem && (mem_size == 2'd3 || bad_align));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      cnt_q        <= '0;
      addr_q       <= '0;
      din_q        <= '0;
      size_q       <= '0;
      op_wr_q      <= 1'b0;
      ret_halted_q <= 1'b0;
      d_rd         <= '0;
      error        <= 1'b0;
      pc           <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      size_q       <= size_d;
      op_wr_q      <= op_wr_d;
      ret_halted_q <= ret_halted_d;
      d_rd         <= d_rd_d;
      error        <= err_d;
      pc           <= mcu_pc;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    din_d        = din_q;
    size_d       = size_q;
    op_wr_d      = op_wr_q;
    ret_halted_d = ret_halted_q;
    d_rd_d       = d_rd;
    err_d        = 1'b0;
    case (state_q)
      ST_RUN, ST_HALTED: begin
        if (valid) begin
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            addr_d  = addr;
            din_d   = d_in;
            size_d  = mem_size;
            op_wr_d = cmd.reg_wr | cmd.mem_wr;
            // pause while halted and resume while running fall through as no-ops
            if (cmd.pause && state_q == ST_RUN) begin
              state_d = ST_DRAIN;
              cnt_d   = CW'(DRAIN_MAX - 1);
            end else if (cmd.resume) begin
              state_d = ST_RUN;
            end else if (cmd.dbg_reset) begin
              state_d      = ST_RST;
              cnt_d        = CW'(RST_CYCLES - 1);
              ret_halted_d = (state_q == ST_HALTED);
            end else if (is_reg) begin
              state_d = ST_REG;
            end else if (is_mem) begin
              state_d = ST_MEM;
              cnt_d   = CW'(MEM_TIMEOUT - 1);
            end
          end
        end
      end
      ST_DRAIN: begin
        if (mcu_idle) begin
          state_d = ST_HALTED;
        end else if (cnt_q == '0) begin
          err_d   = 1'b1;
          state_d = ST_HALTED;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_REG: begin
        if (!op_wr_q) d_rd_d = rf_rd;
        state_d = ST_HALTED;
      end
      ST_MEM: begin
        if (dm_ack) begin
          if (!op_wr_q) d_rd_d = size_mask(size_q, dm_dout);
          state_d = ST_HALTED;
        end else if (cnt_q == '0) begin
          err_d   = 1'b1;
          state_d = ST_HALTED;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RST: begin
        if (cnt_q == '0) state_d = ret_halted_q ? ST_HALTED : ST_RUN;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign mcu_busy  = !(state_q == ST_RUN || state_q == ST_HALTED) || valid;
  assign mcu_stall = (state_q inside {ST_DRAIN, ST_HALTED, ST_REG, ST_MEM}) ||
                     (state_q == ST_RST && ret_halted_q);
  assign mcu_rst   = (state_q == ST_RST);
  assign rf_addr   = addr_q[4:0];
  assign rf_wd     = din_q;
  assign rf_we     = (state_q == ST_REG) && op_wr_q;
  assign dm_addr   = addr_q;
  assign dm_din    = din_q;
  assign dm_size   = size_q;
  assign dm_re     = (state_q == ST_MEM) && !op_wr_q;
  assign dm_we     = (state_q == ST_MEM) && op_wr_q;

endmodule

// File: tb/tb_mcu_debug_bridge.sv
// Self-checking bench for mcu_debug_bridge: vector table, corner sequences, random vs. model.
module tb_mcu_debug_bridge;

  localparam int RST_CYCLES  = 4;
  localparam int MEM_TIMEOUT = 255;
  localparam int DRAIN_MAX   = 63;

  localparam logic [6:0] S_PAUSE  = 7'b1000000;
  localparam logic [6:0] S_RESUME = 7'b0100000;
  localparam logic [6:0] S_DRST   = 7'b0010000;
  localparam logic [6:0] S_RRD    = 7'b0001000;
  localparam logic [6:0] S_RWR    = 7'b0000100;
  localparam logic [6:0] S_MRD    = 7'b0000010;
  localparam logic [6:0] S_MWR    = 7'b0000001;
  localparam logic [6:0] S_NONE   = 7'b0000000;

  logic clk = 1'b0;
  logic reset;
  logic pause, resume, dbg_reset, reg_rd, reg_wr, mem_rd, mem_wr, valid;
  logic [1:0]  mem_size;
  logic [31:0] addr, d_in, d_rd, pc, mcu_pc;
  logic mcu_busy, error, mcu_idle, mcu_stall, mcu_rst, rf_we, dm_re, dm_we, dm_ack;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wd, rf_rd, dm_addr, dm_din, dm_dout;
  logic [1:0]  dm_size;

  mcu_debug_bridge #(.RST_CYCLES(RST_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk(clk), .reset(reset), .pause(pause), .resume(resume), .dbg_reset(dbg_reset),
    .reg_rd(reg_rd), .reg_wr(reg_wr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_size(mem_size),
    .valid(valid), .addr(addr), .d_in(d_in), .d_rd(d_rd), .mcu_busy(mcu_busy), .error(error),
    .pc(pc), .mcu_pc(mcu_pc), .mcu_idle(mcu_idle), .mcu_stall(mcu_stall), .mcu_rst(mcu_rst),
    .rf_addr(rf_addr), .rf_wd(rf_wd), .rf_we(rf_we), .rf_rd(rf_rd), .dm_addr(dm_addr),
    .dm_din(dm_din), .dm_size(dm_size), .dm_re(dm_re), .dm_we(dm_we), .dm_ack(dm_ack),
    .dm_dout(dm_dout)
  );

  always #5 clk = ~clk;

  // Register file: async read, x0 hardwired to zero
  logic [31:0] rf [32];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (rf_we && rf_addr != 5'd0) begin
      rf[rf_addr] <= rf_wd;
    end
  end
  assign rf_rd = (rf_addr == 5'd0) ? 32'd0 : rf[rf_addr];

  // Memory and pipeline responders with programmable latency (ack_lat < 0: never ack)
  int ack_lat = 0, idle_lat = 0, req_cyc = 0, stall_cyc = 0;
  logic [31:0] mem_dout = '0;
  always @(posedge clk) begin
    req_cyc   <= (dm_re || dm_we) ? req_cyc + 1 : 0;
    stall_cyc <= mcu_stall ? stall_cyc + 1 : 0;
  end
  assign dm_ack   = (dm_re || dm_we) && ack_lat >= 0 && req_cyc == ack_lat;
  assign mcu_idle = mcu_stall && stall_cyc >= idle_lat;
  assign dm_dout  = mem_dout;

  int rf_we_cnt = 0, req_cnt = 0, rst_cnt = 0, rst_unstalled = 0;
  logic [31:0] cap_addr = '0, cap_din = '0;
  logic [1:0]  cap_size = '0;
  always @(posedge clk) begin
    if (rf_we) rf_we_cnt++;
    if (dm_re || dm_we) begin
      req_cnt++;
      cap_addr = dm_addr;
      cap_din  = dm_din;
      cap_size = dm_size;
    end
    if (mcu_rst) begin
      rst_cnt++;
      if (!mcu_stall) rst_unstalled++;
    end
  end

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and wait for the bridge to return to an idle state.
  task automatic run_cmd(input logic [6:0] s, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz, output int busy_cyc, output int errs);
    bit done;
    {pause, resume, dbg_reset, reg_rd, reg_wr, mem_rd, mem_wr} = s;
    addr = a; d_in = d; mem_size = sz; valid = 1'b1;
    rf_we_cnt = 0; req_cnt = 0; rst_cnt = 0; rst_unstalled = 0;
    busy_cyc = 0; errs = 0; done = 1'b0;
    #1;
    if (mcu_busy) busy_cyc++;
    step();
    {pause, resume, dbg_reset, reg_rd, reg_wr, mem_rd, mem_wr} = S_NONE;
    valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (error) errs++;
      if (!mcu_busy) begin
        done = 1'b1;
        break;
      end
      busy_cyc++;
      step();
    end
    chk("cmd_completes", 32'(done), 32'd1);
  endtask

  typedef struct {
    string       name;
    logic [6:0]  s;
    logic [31:0] a, d;
    logic [1:0]  sz;
    logic [31:0] dout;
    int          ack, idle, e_err;
    logic        e_stall;
    logic [31:0] e_drd;
    int          e_busy, e_req, e_rfwe;
  } vec_t;

  function automatic vec_t mk(input string n, input logic [6:0] s, input logic [31:0] a,
                              input logic [31:0] d, input logic [1:0] sz, input logic [31:0] dout,
                              input int ack, input int idle, input int e_err, input logic e_stall,
                              input logic [31:0] e_drd, input int e_busy, input int e_req,
                              input int e_rfwe);
    vec_t v;
    v.name = n; v.s = s; v.a = a; v.d = d; v.sz = sz; v.dout = dout; v.ack = ack; v.idle = idle;
    v.e_err = e_err; v.e_stall = e_stall; v.e_drd = e_drd; v.e_busy = e_busy;
    v.e_req = e_req; v.e_rfwe = e_rfwe;
    return v;
  endfunction

  vec_t tbl[$];
  logic [31:0] m_rf [32];
  logic        m_halted;
  logic [31:0] m_drd;

  initial begin
    int bc, ec;
    reset = 1'b1; valid = 1'b0; mem_size = '0; addr = '0; d_in = '0; mcu_pc = 32'h0000_0400;
    {pause, resume, dbg_reset, reg_rd, reg_wr, mem_rd, mem_wr} = S_NONE;
    repeat (2) step();
    chk("rst_d_rd", d_rd, 0);
    chk("rst_pc", pc, 0);
    chk("rst_outs", {error, mcu_stall, mcu_rst, rf_we, dm_re, dm_we, mcu_busy}, 0);
    reset = 1'b0;
    step();
    chk("pc_follow", pc, 32'h0000_0400);

    //          name        strobe           addr          d_in          sz    dout          ack idle err stl drd           busy req rfwe
    tbl.push_back(mk("pause_drain", S_PAUSE,  0,            0,            2'd0, 0,             0, 2, 0, 1, 0,            4, 0, 0));
    tbl.push_back(mk("reg_wr5",     S_RWR,    5,            32'hDEADBEEF, 2'd0, 0,             0, 0, 0, 1, 0,            2, 0, 1));
    tbl.push_back(mk("reg_rd5",     S_RRD,    5,            0,            2'd0, 0,             0, 0, 0, 1, 32'hDEADBEEF, 2, 0, 0));
    tbl.push_back(mk("half_mis",    S_MRD,    32'h103,      0,            2'd1, 32'h1234ABCD,  1, 0, 1, 1, 32'hDEADBEEF, 1, 0, 0));
    tbl.push_back(mk("half_rd",     S_MRD,    32'h102,      0,            2'd1, 32'h1234ABCD,  1, 0, 0, 1, 32'h0000ABCD, 3, 2, 0));
    tbl.push_back(mk("byte_rd",     S_MRD,    32'h7,        0,            2'd0, 32'h89ABCDEF,  0, 0, 0, 1, 32'h000000EF, 2, 1, 0));
    tbl.push_back(mk("word_mis",    S_MRD,    32'h102,      0,            2'd2, 32'h11111111,  0, 0, 1, 1, 32'h000000EF, 1, 0, 0));
    tbl.push_back(mk("size3",       S_MRD,    32'h100,      0,            2'd3, 32'h11111111,  0, 0, 1, 1, 32'h000000EF, 1, 0, 0));
    tbl.push_back(mk("reg_range",   S_RRD,    32'h20,       0,            2'd0, 0,             0, 0, 1, 1, 32'h000000EF, 1, 0, 0));
    tbl.push_back(mk("two_mem",     S_MRD|S_MWR, 32'h100,   0,            2'd2, 0,             0, 0, 1, 1, 32'h000000EF, 1, 0, 0));
    tbl.push_back(mk("no_strobe",   S_NONE,   0,            0,            2'd0, 0,             0, 0, 1, 1, 32'h000000EF, 1, 0, 0));
    tbl.push_back(mk("reg_wr0",     S_RWR,    0,            32'h55,       2'd0, 0,             0, 0, 0, 1, 32'h000000EF, 2, 0, 1));
    tbl.push_back(mk("reg_rd0",     S_RRD,    0,            0,            2'd0, 0,             0, 0, 0, 1, 0,            2, 0, 0));
    tbl.push_back(mk("word_wr",     S_MWR,    32'h200,      32'hCAFE0011, 2'd2, 0,             2, 0, 0, 1, 0,            4, 3, 0));
    tbl.push_back(mk("resume",      S_RESUME, 0,            0,            2'd0, 0,             0, 0, 0, 0, 0,            1, 0, 0));
    tbl.push_back(mk("reg_in_run",  S_RRD,    5,            0,            2'd0, 0,             0, 0, 1, 0, 0,            1, 0, 0));
    tbl.push_back(mk("pause_resume",S_PAUSE|S_RESUME, 0,    0,            2'd0, 0,             0, 0, 1, 0, 0,            1, 0, 0));
    tbl.push_back(mk("resume_run",  S_RESUME, 0,            0,            2'd0, 0,             0, 0, 0, 0, 0,            1, 0, 0));
    tbl.push_back(mk("dbgrst_run",  S_DRST,   0,            0,            2'd0, 0,             0, 0, 0, 0, 0,            5, 0, 0));
    tbl.push_back(mk("pause_fast",  S_PAUSE,  0,            0,            2'd0, 0,             0, 0, 0, 1, 0,            2, 0, 0));

    foreach (tbl[i]) begin
      mem_dout = tbl[i].dout; ack_lat = tbl[i].ack; idle_lat = tbl[i].idle;
      run_cmd(tbl[i].s, tbl[i].a, tbl[i].d, tbl[i].sz, bc, ec);
      chk({tbl[i].name, "_err"}, 32'(ec), 32'(tbl[i].e_err));
      chk({tbl[i].name, "_stall"}, 32'(mcu_stall), 32'(tbl[i].e_stall));
      chk({tbl[i].name, "_drd"}, d_rd, tbl[i].e_drd);
      chk({tbl[i].name, "_busy"}, 32'(bc), 32'(tbl[i].e_busy));
      chk({tbl[i].name, "_req"}, 32'(req_cnt), 32'(tbl[i].e_req));
      chk({tbl[i].name, "_rfwe"}, 32'(rf_we_cnt), 32'(tbl[i].e_rfwe));
      if (tbl[i].s == S_MWR) chk("word_wr_din", cap_din, tbl[i].d);
    end

    // Memory timeouts: request held MEM_TIMEOUT cycles, error, d_rd untouched
    ack_lat = -1; mem_dout = 32'hFFFF_FFFF;
    run_cmd(S_RRD, 5, 0, 2'd0, bc, ec);
    run_cmd(S_MRD, 32'h300, 0, 2'd2, bc, ec);
    chk("rd_to_req", 32'(req_cnt), 32'(MEM_TIMEOUT));
    chk("rd_to_err", 32'(ec), 1);
    chk("rd_to_drd", d_rd, 32'hDEADBEEF);
    run_cmd(S_MWR, 32'h304, 32'h0BAD_F00D, 2'd2, bc, ec);
    chk("wr_to_req", 32'(req_cnt), 32'(MEM_TIMEOUT));
    chk("wr_to_busy", 32'(bc), 32'(MEM_TIMEOUT + 1));
    chk("wr_to_err", 32'(ec), 1);
    chk("wr_to_idle", 32'({mcu_busy, dm_we}), 0);

    // Debug reset while halted keeps the stall
    run_cmd(S_DRST, 0, 0, 2'd0, bc, ec);
    chk("hrst_cycles", 32'(rst_cnt), 32'(RST_CYCLES));
    chk("hrst_unstalled", 32'(rst_unstalled), 0);
    chk("hrst_stall", 32'(mcu_stall), 1);
    chk("hrst_err", 32'(ec), 0);

    // Drain timeout: error, but stall kept and state is HALTED
    run_cmd(S_RESUME, 0, 0, 2'd0, bc, ec);
    idle_lat = 1000;
    run_cmd(S_PAUSE, 0, 0, 2'd0, bc, ec);
    chk("drain_to_busy", 32'(bc), 32'(DRAIN_MAX + 1));
    chk("drain_to_err", 32'(ec), 1);
    chk("drain_to_stall", 32'(mcu_stall), 1);
    run_cmd(S_RRD, 5, 0, 2'd0, bc, ec);
    chk("drain_to_halted", 32'(ec), 0);

    // Randomized commands against a behavioural model
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_rf[5] = 32'hDEADBEEF;
    m_halted = 1'b1;
    m_drd = 32'hDEADBEEF;
    for (int n = 0; n < 200; n++) begin
      logic [6:0] s;
      logic [31:0] a, d;
      logic [1:0] sz;
      bit is_reg, is_mem, legal;
      int k, e_req, e_rfwe;
      k = $urandom_range(0, 11);
      if (k == 0) s = S_NONE;
      else if (k == 1) s = 7'(1 << $urandom_range(0, 6)) | 7'(1 << $urandom_range(0, 6));
      else s = 7'(1 << $urandom_range(0, 6));
      a = $urandom; d = $urandom; sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFC;
      if ((s & (S_RRD | S_RWR)) != 0 && $urandom_range(0, 7) != 0) a = a % 32;
      mem_dout = $urandom; ack_lat = $urandom_range(0, 4); idle_lat = $urandom_range(0, 4);

      is_reg = (s & (S_RRD | S_RWR)) != 0;
      is_mem = (s & (S_MRD | S_MWR)) != 0;
      legal  = ($countones(s) == 1) && !((is_reg || is_mem) && !m_halted) &&
               !(is_reg && a > 31) &&
               !(is_mem && (sz == 3 || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0)));
      e_req = 0; e_rfwe = 0;
      if (legal) begin
        if (s == S_PAUSE) m_halted = 1'b1;
        else if (s == S_RESUME) m_halted = 1'b0;
        else if (s == S_RRD) m_drd = m_rf[a % 32];
        else if (s == S_RWR) begin
          e_rfwe = 1;
          if (a != 0) m_rf[a % 32] = d;
        end else if (is_mem) begin
          e_req = ack_lat + 1;
          if (s == S_MRD) m_drd = (sz == 0) ? mem_dout % 256 : (sz == 1) ? mem_dout % 65536 : mem_dout;
        end
      end

      run_cmd(s, a, d, sz, bc, ec);
      chk("rnd_err", 32'(ec), legal ? 0 : 1);
      chk("rnd_stall", 32'(mcu_stall), 32'(m_halted));
      chk("rnd_drd", d_rd, m_drd);
      chk("rnd_req", 32'(req_cnt), 32'(e_req));
      chk("rnd_rfwe", 32'(rf_we_cnt), 32'(e_rfwe));
      if (legal && is_mem) begin
        chk("rnd_dm_addr", cap_addr, a);
        chk("rnd_dm_size", 32'(cap_size), 32'(sz));
        if (s == S_MWR) chk("rnd_dm_din", cap_din, d);
      end
    end

    // Asynchronous reset in the middle of a memory access
    idle_lat = 0;
    if (!mcu_stall) run_cmd(S_PAUSE, 0, 0, 2'd0, bc, ec);
    run_cmd(S_RRD, 5, 0, 2'd0, bc, ec);
    ack_lat = -1;
    {pause, resume, dbg_reset, reg_rd, reg_wr, mem_rd, mem_wr} = S_MRD;
    addr = 32'h400; mem_size = 2'd2; valid = 1'b1;
    step();
    {pause, resume, dbg_reset, reg_rd, reg_wr, mem_rd, mem_wr} = S_NONE;
    valid = 1'b0;
    repeat (3) step();
    chk("pre_rst_dm_re", 32'(dm_re), 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_outs", {error, mcu_stall, mcu_rst, rf_we, dm_re, dm_we, mcu_busy}, 0);
    chk("arst_d_rd", d_rd, 0);
    chk("arst_pc", pc, 0);
    step();
    reset = 1'b0;
    rf_we_cnt = 0; req_cnt = 0;
    repeat (3) step();
    chk("post_rst_idle", 32'({error, mcu_stall, mcu_busy, dm_re}), 0);
    chk("post_rst_req", 32'(req_cnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
